pgm_sdram_arbiter: RTL and testbench

- Shares the single board SDRAM controller user port between three PGM requesters: video fetch (tile/sprite ROM reads), 68000 bus (program ROM/RAM), and Z80 sound (sample ROM/shared RAM).
- Sits between the PGM core and the SDRAM controller inside the MiSTer framework.
- One transaction outstanding at a time.
- Fixed priority video > 68k > Z80, with an anti-starvation promotion for 68k and Z80.

---
 rtl/pgm_pkg.sv | 19 +
 rtl/pgm_arb_select.sv | 39 +++
 rtl/pgm_sdram_arbiter.sv | 149 ++++++++++++++
 tb/tb_pgm_sdram_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pgm_pkg.sv
// rtl/pgm_pkg.sv - shared owner codes, FSM states and bus widths for the PGM SDRAM arbiter
package pgm_pkg;

  localparam int PGM_AW = 25;
  localparam int PGM_DW = 16;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_Z80  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/pgm_arb_select.sv
// rtl/pgm_arb_select.sv - combinational winner pick and starvation-counter next values
module pgm_arb_select
  import pgm_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          vid_req,
  input  logic          cpu_req,
  input  logic          z80_req,
  input  logic [CW-1:0] cpu_starve,
  input  logic [CW-1:0] z80_starve,
  output logic [1:0]    winner,
  output logic [CW-1:0] cpu_starve_nxt,
  output logic [CW-1:0] z80_starve_nxt
);

  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  always_comb begin
    winner = OWN_NONE;
    if (cpu_req && cpu_starve == SMAX)      winner = OWN_CPU;
    else if (z80_req && z80_starve == SMAX) winner = OWN_Z80;
    else if (vid_req)                       winner = OWN_VID;
    else if (cpu_req)                       winner = OWN_CPU;
    else if (z80_req)                       winner = OWN_Z80;
  end

  // Losers that are still asking age toward promotion; idle or winning ports restart at zero.
  always_comb begin
    cpu_starve_nxt = '0;
    z80_starve_nxt = '0;
    if (cpu_req && winner != OWN_CPU)
      cpu_starve_nxt = (cpu_starve == SMAX) ? SMAX : cpu_starve + CW'(1);
    if (z80_req && winner != OWN_Z80)
      z80_starve_nxt = (z80_starve == SMAX) ? SMAX : z80_starve + CW'(1);
  end

endmodule

// File: rtl/pgm_sdram_arbiter.sv
// rtl/pgm_sdram_arbiter.sv - shares the SDRAM user port between video, 68k and Z80 requesters
module pgm_sdram_arbiter
  import pgm_pkg::*;
#(
  parameter int AW         = PGM_AW,
  parameter int DW         = PGM_DW,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [1:0]    cpu_be,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          z80_req,
  input  logic          z80_we,
  input  logic [AW-1:0] z80_addr,
  input  logic [DW-1:0] z80_wdata,
  input  logic [1:0]    z80_be,
  output logic          z80_ack,
  output logic [DW-1:0] z80_rdata,
  output logic          sd_req,
  output logic          sd_we,
  output logic [AW-1:0] sd_addr,
  output logic [DW-1:0] sd_wdata,
  output logic [1:0]    sd_be,
  input  logic          sd_gnt,
  input  logic          sd_done,
  input  logic [DW-1:0] sd_rdata,
  output logic [1:0]    gnt_id
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_t    state;
  logic [CW-1:0] cpu_starve, z80_starve;
  logic [CW-1:0] cpu_starve_nxt, z80_starve_nxt;
  logic [1:0]    winner;
  logic          done_now;

  pgm_arb_select #(.STARVE_MAX(STARVE_MAX), .CW(CW)) u_select (
    .vid_req        (vid_req),
    .cpu_req        (cpu_req),
    .z80_req        (z80_req),
    .cpu_starve     (cpu_starve),
    .z80_starve     (z80_starve),
    .winner         (winner),
    .cpu_starve_nxt (cpu_starve_nxt),
    .z80_starve_nxt (z80_starve_nxt)
  );

  // The controller may report completion in the very cycle it accepts the command.
  assign done_now = ((state == ST_ISSUE) && sd_gnt && sd_done) ||
                    ((state == ST_WAIT) && sd_done);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sd_req     <= 1'b0;
      sd_we      <= 1'b0;
      sd_addr    <= '0;
      sd_wdata   <= '0;
      sd_be      <= 2'b00;
      gnt_id     <= OWN_NONE;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      z80_ack    <= 1'b0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
      z80_rdata  <= '0;
      cpu_starve <= '0;
      z80_starve <= '0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      z80_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          cpu_starve <= cpu_starve_nxt;
          z80_starve <= z80_starve_nxt;
          if (winner != OWN_NONE) begin
            gnt_id <= winner;
            sd_req <= 1'b1;
            state  <= ST_ISSUE;
            case (winner)
              OWN_VID: begin
                sd_addr  <= vid_addr;
                sd_we    <= 1'b0;
                sd_wdata <= '0;
                sd_be    <= 2'b11;
              end
              OWN_CPU: begin
                sd_addr  <= cpu_addr;
                sd_we    <= cpu_we;
                sd_wdata <= cpu_wdata;
                sd_be    <= cpu_be;
              end
              default: begin
                sd_addr  <= z80_addr;
                sd_we    <= z80_we;
                sd_wdata <= z80_wdata;
                sd_be    <= z80_be;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (sd_gnt) begin
            sd_req <= 1'b0;
            state  <= sd_done ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sd_done) state <= ST_ACK;
        end
        default: begin
          gnt_id <= OWN_NONE;
          state  <= ST_IDLE;
        end
      endcase

      if (done_now) begin
        case (gnt_id)
          OWN_VID: begin
            vid_ack   <= 1'b1;
            vid_rdata <= sd_rdata;
          end
          OWN_CPU: begin
            cpu_ack <= 1'b1;
            if (!sd_we) cpu_rdata <= sd_rdata;
          end
          OWN_Z80: begin
            z80_ack <= 1'b1;
            if (!sd_we) z80_rdata <= sd_rdata;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pgm_sdram_arbiter.sv
// tb/tb_pgm_sdram_arbiter.sv - directed self-checking bench for pgm_sdram_arbiter
module tb_pgm_sdram_arbiter;
  import pgm_pkg::*;

  logic        FPGA_CLK1_50 = 1'b0;
  logic        reset_n = 1'b1;
  logic        vid_req = 1'b0;
  logic [24:0] vid_addr = '0;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [1:0]  cpu_be = 2'b11;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        z80_req = 1'b0, z80_we = 1'b0;
  logic [24:0] z80_addr = '0;
  logic [15:0] z80_wdata = '0;
  logic [1:0]  z80_be = 2'b11;
  logic        z80_ack;
  logic [15:0] z80_rdata;
  logic        sd_req, sd_we;
  logic [24:0] sd_addr;
  logic [15:0] sd_wdata;
  logic [1:0]  sd_be;
  logic        sd_gnt = 1'b0, sd_done = 1'b0;
  logic [15:0] sd_rdata = '0;
  logic [1:0]  gnt_id;

  int n_cmp = 0;
  int n_err = 0;

  always #10 FPGA_CLK1_50 = ~FPGA_CLK1_50;

  pgm_sdram_arbiter dut (
    .clk_sys(FPGA_CLK1_50), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr), .z80_wdata(z80_wdata),
    .z80_be(z80_be), .z80_ack(z80_ack), .z80_rdata(z80_rdata),
    .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_be(sd_be),
    .sd_gnt(sd_gnt), .sd_done(sd_done), .sd_rdata(sd_rdata), .gnt_id(gnt_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Plays the SDRAM controller for one transaction: gd cycles before sd_gnt, sd_done dd cycles after it.
  task automatic serve(input logic [1:0] own, input logic [24:0] addr, input logic we,
                       input logic [1:0] be, input logic [15:0] wd, input int gd, input int dd,
                       input logic [15:0] rd, input logic [15:0] exp_rdata, input logic drop);
    int w;
    logic [2:0]  ev;
    logic [15:0] rv;
    w = 0;
    while (sd_req !== 1'b1 && w < 20) begin
      @(negedge FPGA_CLK1_50);
      w++;
    end
    chk("sd_req_seen", {31'd0, sd_req}, 32'd1);
    if (sd_req !== 1'b1) return;
    chk("issue_gnt_id", {30'd0, gnt_id}, {30'd0, own});
    chk("sd_addr", {7'd0, sd_addr}, {7'd0, addr});
    chk("sd_we", {31'd0, sd_we}, {31'd0, we});
    chk("sd_be", {30'd0, sd_be}, {30'd0, be});
    if (we) chk("sd_wdata", {16'd0, sd_wdata}, {16'd0, wd});
    for (int i = 0; i < gd; i++) begin
      @(negedge FPGA_CLK1_50);
      chk("hold_sd_req", {31'd0, sd_req}, 32'd1);
      chk("hold_sd_addr", {7'd0, sd_addr}, {7'd0, addr});
    end
    sd_gnt = 1'b1;
    if (dd == 0) begin
      sd_done  = 1'b1;
      sd_rdata = rd;
    end
    @(negedge FPGA_CLK1_50);
    sd_gnt  = 1'b0;
    sd_done = 1'b0;
    chk("sd_req_drop", {31'd0, sd_req}, 32'd0);
    if (dd > 0) begin
      for (int j = 1; j < dd; j++) @(negedge FPGA_CLK1_50);
      sd_done  = 1'b1;
      sd_rdata = rd;
      @(negedge FPGA_CLK1_50);
      sd_done = 1'b0;
    end
    case (own)
      OWN_VID: begin ev = 3'b100; rv = vid_rdata; end
      OWN_CPU: begin ev = 3'b010; rv = cpu_rdata; end
      default: begin ev = 3'b001; rv = z80_rdata; end
    endcase
    chk("ack_vec", {29'd0, vid_ack, cpu_ack, z80_ack}, {29'd0, ev});
    chk("ack_gnt_id", {30'd0, gnt_id}, {30'd0, own});
    chk("rdata", {16'd0, rv}, {16'd0, exp_rdata});
    if (drop) begin
      case (own)
        OWN_VID: vid_req = 1'b0;
        OWN_CPU: cpu_req = 1'b0;
        default: z80_req = 1'b0;
      endcase
    end
    @(negedge FPGA_CLK1_50);
    chk("ack_one_cycle", {29'd0, vid_ack, cpu_ack, z80_ack}, 32'd0);
    chk("gnt_id_release", {30'd0, gnt_id}, 32'd0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #3;
    chk("rst_sd_req", {31'd0, sd_req}, 32'd0);
    chk("rst_sd_we", {31'd0, sd_we}, 32'd0);
    chk("rst_sd_addr", {7'd0, sd_addr}, 32'd0);
    chk("rst_sd_be", {30'd0, sd_be}, 32'd0);
    chk("rst_gnt_id", {30'd0, gnt_id}, 32'd0);
    chk("rst_acks", {29'd0, vid_ack, cpu_ack, z80_ack}, 32'd0);
    chk("rst_rdata", {vid_rdata, cpu_rdata | z80_rdata}, 32'd0);
    repeat (2) @(negedge FPGA_CLK1_50);
    reset_n = 1'b1;
    @(negedge FPGA_CLK1_50);

    // Single video read.
    vid_addr = 25'h0001234;
    vid_req  = 1'b1;
    serve(OWN_VID, 25'h0001234, 1'b0, 2'b11, 16'h0, 0, 2, 16'hBEEF, 16'hBEEF, 1'b1);
    repeat (3) @(negedge FPGA_CLK1_50);
    chk("vid_single_sd_req", {31'd0, sd_req}, 32'd0);

    // 68k lower-byte write; cpu_rdata must not pick up the bus value.
    cpu_we = 1'b1; cpu_addr = 25'h0000100; cpu_wdata = 16'hA55A; cpu_be = 2'b01;
    cpu_req = 1'b1;
    serve(OWN_CPU, 25'h0000100, 1'b1, 2'b01, 16'hA55A, 0, 1, 16'hDEAD, 16'h0000, 1'b1);
    chk("vid_rdata_kept", {16'd0, vid_rdata}, 32'h0000BEEF);

    // All three at once: video, then 68k, then Z80.
    vid_addr = 25'h0002000;
    cpu_we = 1'b0; cpu_addr = 25'h0000300; cpu_be = 2'b11;
    z80_we = 1'b0; z80_addr = 25'h0000400; z80_be = 2'b10;
    vid_req = 1'b1; cpu_req = 1'b1; z80_req = 1'b1;
    serve(OWN_VID, 25'h0002000, 1'b0, 2'b11, 16'h0, 0, 3, 16'h1111, 16'h1111, 1'b1);
    serve(OWN_CPU, 25'h0000300, 1'b0, 2'b11, 16'h0, 0, 3, 16'h2222, 16'h2222, 1'b1);
    serve(OWN_Z80, 25'h0000400, 1'b0, 2'b10, 16'h0, 0, 3, 16'h3333, 16'h3333, 1'b1);

    // Starvation: Z80 loses eight times to a continuous video stream, then is promoted.
    vid_addr = 25'h0005000;
    z80_addr = 25'h0000600; z80_be = 2'b11;
    vid_req = 1'b1; z80_req = 1'b1;
    for (int k = 0; k < 8; k++)
      serve(OWN_VID, 25'h0005000, 1'b0, 2'b11, 16'h0, 0, 1, 16'h0100 + 16'(k), 16'h0100 + 16'(k), 1'b0);
    serve(OWN_Z80, 25'h0000600, 1'b0, 2'b11, 16'h0, 0, 1, 16'h7777, 16'h7777, 1'b0);
    serve(OWN_VID, 25'h0005000, 1'b0, 2'b11, 16'h0, 0, 1, 16'h0A0A, 16'h0A0A, 1'b1);
    serve(OWN_Z80, 25'h0000600, 1'b0, 2'b11, 16'h0, 0, 1, 16'h8888, 16'h8888, 1'b1);

    // Slow controller: sd_gnt five cycles late.
    cpu_addr = 25'h00ABCDE; cpu_we = 1'b0; cpu_be = 2'b11;
    cpu_req = 1'b1;
    serve(OWN_CPU, 25'h00ABCDE, 1'b0, 2'b11, 16'h0, 5, 1, 16'h4242, 16'h4242, 1'b1);

    // Reset in the middle of a 68k read.
    cpu_addr = 25'h0000777;
    cpu_req = 1'b1;
    for (int w = 0; w < 20 && sd_req !== 1'b1; w++) @(negedge FPGA_CLK1_50);
    chk("rst_txn_sd_req", {31'd0, sd_req}, 32'd1);
    sd_gnt = 1'b1;
    @(negedge FPGA_CLK1_50);
    sd_gnt = 1'b0;
    chk("rst_txn_wait_owner", {30'd0, gnt_id}, {30'd0, OWN_CPU});
    reset_n = 1'b0;
    #1;
    chk("midrst_sd_req", {31'd0, sd_req}, 32'd0);
    chk("midrst_gnt_id", {30'd0, gnt_id}, 32'd0);
    chk("midrst_sd_addr", {7'd0, sd_addr}, 32'd0);
    chk("midrst_sd_be", {30'd0, sd_be}, 32'd0);
    chk("midrst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("midrst_vid_rdata", {16'd0, vid_rdata}, 32'd0);
    chk("midrst_acks", {29'd0, vid_ack, cpu_ack, z80_ack}, 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge FPGA_CLK1_50);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge FPGA_CLK1_50);
      chk("postrst_no_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    end
    vid_addr = 25'h0000042;
    vid_req = 1'b1;
    serve(OWN_VID, 25'h0000042, 1'b0, 2'b11, 16'h0, 0, 2, 16'hCAFE, 16'hCAFE, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
